cordic_rotator: RTL

CORDIC_ROTATOR -- requirements
Module: cordic_rotator

---
 rtl/cordic_rotator.sv | 129 ++++++++++++
 1 files changed

// File: rtl/cordic_rotator.sv
// Iterative CORDIC rotator in rotation mode.
// One micro-rotation per clock; the arctangent table lives outside the block
// and is addressed through lut_index / lut_angle in the same cycle.
// ITER must lie in 1..17 to match the 17-entry arctangent table.
// The caller pre-scales x_in by 1/K. No gain compensation is applied here.
module cordic_rotator #(
   parameter int WIDTH = 18,
   parameter int ITER  = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] y_in,
   input  logic [WIDTH-1:0] z_in,
   output logic [4:0]       lut_index,
   input  logic [WIDTH-1:0] lut_angle,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] x_out,
   output logic [WIDTH-1:0] y_out,
   output logic [WIDTH-1:0] z_out
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ROTATE,
      ST_DONE
   } state_t;

   localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

   state_t                  state_q, state_d;
   logic [4:0]              cnt_q, cnt_d;
   logic signed [WIDTH-1:0] x_q, x_d;
   logic signed [WIDTH-1:0] y_q, y_d;
   logic signed [WIDTH-1:0] z_q, z_d;

   // One micro-rotation worth of datapath, derived from the working registers.
   logic signed [WIDTH-1:0] x_shift;
   logic signed [WIDTH-1:0] y_shift;
   logic signed [WIDTH-1:0] angle;
   logic                    rot_pos;
   logic signed [WIDTH-1:0] x_rot;
   logic signed [WIDTH-1:0] y_rot;
   logic signed [WIDTH-1:0] z_rot;

   // Micro-rotation: direction follows the sign of the residual angle; all sums wrap.
   always_comb begin
      x_shift = x_q >>> cnt_q;
      y_shift = y_q >>> cnt_q;
      angle   = $signed(lut_angle);
      rot_pos = ~z_q[WIDTH-1];
      if (rot_pos) begin
         x_rot = x_q - y_shift;
         y_rot = y_q + x_shift;
         z_rot = z_q - angle;
      end else begin
         x_rot = x_q + y_shift;
         y_rot = y_q - x_shift;
         z_rot = z_q + angle;
      end
   end

   // Next-state and register-update logic for the IDLE -> ROTATE -> DONE sequence.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ROTATE;
               cnt_d   = '0;
               x_d     = $signed(x_in);
               y_d     = $signed(y_in);
               z_d     = $signed(z_in);
            end
         end
         ST_ROTATE: begin
            x_d = x_rot;
            y_d = y_rot;
            z_d = z_rot;
            if (cnt_q == LAST_ITER) begin
               state_d = ST_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         ST_DONE: begin
            // Results stay in x/y/z until the next accepted start.
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and working registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
      end
   end

   assign busy      = (state_q == ST_ROTATE);
   assign done      = (state_q == ST_DONE);
   assign lut_index = busy ? cnt_q : 5'd0;
   assign x_out     = x_q;
   assign y_out     = y_q;
   assign z_out     = z_q;

endmodule
